dmem_bytelane: RTL and testbench
================================

Name: dmem_bytelane

Overview:
- Parametrised data memory for the MIPS datapath. Replaces the fixed 32-word, word-only, combinational-read data memory.
- Supports byte, halfword and word loads and stores through byte-lane write enables, with sign or zero extension on loads.
- Uses a synchronous read with configurable latency and a request/response handshake, so the memory stage can stall.
- Flags misaligned, illegal-size and out-of-range accesses instead of silently aliasing them.

Parameters:
- ADDR_WIDTH, 32, width of the byte address.
- DEPTH_WORDS, 256, number of 32-bit words; must be a power of two, at least 2.
- READ_LATENCY, 1, cycles from the request-accept edge to rsp_valid; legal values are 1 or 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend (lbu/lhu), 0 = sign-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result after extension; 0 for stores and for faults.
- rsp_fault  out  1  access rejected.

Behaviour:
- State machine: IDLE, PIPE, RESP.
  - IDLE: req_ready=1. Handshake is req_valid&&req_ready at a rising edge. On accept, go to PIPE if READ_LATENCY=2, otherwise go to RESP.
  - PIPE: one cycle, req_ready=0, then go to RESP.
  - RESP: rsp_valid=1, req_ready=0. Hold rsp_rdata and rsp_fault stable until rsp_ready=1 at an edge, then go to IDLE.
- Only one request is outstanding at a time. After a response handshake, req_ready is 1 starting the next cycle (no same-cycle turnaround).
- Latency: with READ_LATENCY=1, rsp_valid is high in the cycle right after the accept edge. With READ_LATENCY=2, it is high one cycle later. Stores and faults use the same latency as loads.
- Word index = req_addr[log2(DEPTH_WORDS)+1:2]; lane = req_addr[1:0].
- Fault conditions, evaluated at the accept edge:
  - req_size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - any set bit in req_addr[ADDR_WIDTH-1:log2(DEPTH_WORDS)+2].
- On a fault: no memory write, rsp_fault=1, rsp_rdata=0.
- Stores (little-endian lanes; byte k = word[8k+7:8k]):
  - the array is written at the accept edge;
  - byte: lane addr[1:0] gets wdata[7:0];
  - half: lanes addr[1]*2 and addr[1]*2+1 get wdata[15:0];
  - word: all lanes get wdata;
  - unselected lanes keep their old contents.
- Loads:
  - the word is read synchronously at the accept edge;
  - byte: select lane addr[1:0]; half: select lanes {addr[1],0..1}; word: whole word;
  - extend to 32 bits per req_unsigned; req_unsigned is ignored for word loads.
- Reset (async assert):
  - state goes to IDLE; rsp_valid=0, rsp_fault=0, rsp_rdata=0;
  - req_ready=0 while rst_n=0;
  - memory contents are not reset (undefined until written).
- Reset mid-operation:
  - a pending response is discarded;
  - a store accepted on an earlier edge has already committed and stays committed;
  - no response appears after release.
- Inputs are ignored outside IDLE, and req_* may change freely then. req_wdata/addr need only be valid on the accept edge.
- rsp_ready is ignored while rsp_valid=0.

Test Plan:
- Word store then load: sw 0xDEADBEEF @0x10, then lw @0x10 -> rdata=0xDEADBEEF, fault=0. rsp_valid is high exactly READ_LATENCY cycles after each accept edge.
- Byte lanes: sw 0x00000000 @0x20; sb 0xA5 @0x21; sh 0x8001 @0x22; lw @0x20 -> 0x8001A500. lb @0x21 -> 0xFFFFFFA5. lbu @0x21 -> 0x000000A5. lh @0x22 -> 0xFFFF8001. lhu @0x22 -> 0x00008001.
- Faults: lw @0x22, sh @0x13, size=11, and sw @(DEPTH_WORDS*4) each give fault=1 and rdata=0. A following lw @0x20 still returns 0x8001A500, proving no corrupting write.
- Backpressure: hold rsp_ready=0 for 5 cycles on a load -> rsp_valid and rdata are stable throughout, and req_ready=0. Raise rsp_ready -> req_ready=1 on the next cycle.
- Reset mid-op: accept lw, assert rst_n=0 before the response -> rsp_valid=0 immediately and stays 0 after release. A prior sw 0x12345678 @0x30 reads back 0x12345678.
- Latency sweep: run the second scenario with READ_LATENCY=1 and READ_LATENCY=2 -> identical data, and response timing shifts by one cycle.

Source files
------------

// File: rtl/dmem_if.sv
// Request/response bus between the memory stage and the byte-lane data memory.
interface dmem_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_fault;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/dmem_bytelane.sv
// Data memory with byte/half/word access, load extension, fault detection and a
// one-outstanding request/response handshake with 1- or 2-cycle read latency.
module dmem_bytelane #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DEPTH_WORDS  = 256,
    parameter int unsigned READ_LATENCY = 1
) (
    input logic   clk,
    input logic   rst_n,
    dmem_if.slave bus
);
    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StPipe, StResp} state_e;

    state_e                state_q;
    logic                  rsp_valid_q;
    logic                  write_q;
    logic                  fault_q;
    logic                  unsigned_q;
    logic [1:0]            size_q;
    logic [1:0]            lane_q;
    logic [31:0]           rd_word_q;
    logic [31:0]           mem [DEPTH_WORDS];

    logic [ADDR_WIDTH-1:0] addr;
    logic [IdxW-1:0]       idx;
    logic [1:0]            lane;
    logic                  accept;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  fault;
    logic [3:0]            be;
    logic [31:0]           wlanes;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [31:0]           ext;

    assign addr         = bus.req_addr;
    assign idx          = addr[IdxW+1:2];
    assign lane         = addr[1:0];
    assign out_of_range = |(addr >> (IdxW + 2));
    assign fault        = misaligned || out_of_range;

    assign bus.req_ready = rst_n && (state_q == StIdle);
    assign accept        = bus.req_valid && bus.req_ready;

    // Lane enables and store data replicated across lanes so each lane picks its own slice.
    always_comb begin
        misaligned = 1'b0;
        be         = 4'b0000;
        wlanes     = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                be     = 4'b0001 << lane;
                wlanes = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = lane[0];
                be         = lane[1] ? 4'b1100 : 4'b0011;
                wlanes     = {2{bus.req_wdata[15:0]}};
            end
            2'b10: begin
                misaligned = |lane;
                be         = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase
    end

    // Array is not reset; accept is already low while rst_n is asserted.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_word_q <= mem[idx];
            if (bus.req_write && !fault) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) mem[idx][8*k +: 8] <= wlanes[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            write_q     <= 1'b0;
            fault_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            size_q      <= 2'b00;
            lane_q      <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        write_q    <= bus.req_write;
                        fault_q    <= fault;
                        unsigned_q <= bus.req_unsigned;
                        size_q     <= bus.req_size;
                        lane_q     <= lane;
                        if (READ_LATENCY == 2) begin
                            state_q <= StPipe;
                        end else begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                StPipe: begin
                    state_q     <= StResp;
                    rsp_valid_q <= 1'b1;
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        byte_sel = rd_word_q[8*lane_q +: 8];
        half_sel = lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        case (size_q)
            2'b00:   ext = unsigned_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   ext = unsigned_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: ext = rd_word_q;
        endcase
    end

    // Gating on rsp_valid keeps outputs at zero through reset and between responses.
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_fault = rsp_valid_q && fault_q;
    assign bus.rsp_rdata = (rsp_valid_q && !fault_q && !write_q) ? ext : 32'h0;
endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed bench: drives a latency-1 and a latency-2 instance with identical stimulus.
module tb_dmem_bytelane;
    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        f;
        logic [31:0] exp;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_ready = 1'b1;
    int          errors = 0;
    int          checks = 0;

    dmem_if #(.ADDR_WIDTH(32)) bus1 ();
    dmem_if #(.ADDR_WIDTH(32)) bus2 ();

    assign bus1.req_valid    = req_valid;
    assign bus1.req_write    = req_write;
    assign bus1.req_size     = req_size;
    assign bus1.req_unsigned = req_unsigned;
    assign bus1.req_addr     = req_addr;
    assign bus1.req_wdata    = req_wdata;
    assign bus1.rsp_ready    = rsp_ready;
    assign bus2.req_valid    = req_valid;
    assign bus2.req_write    = req_write;
    assign bus2.req_size     = req_size;
    assign bus2.req_unsigned = req_unsigned;
    assign bus2.req_addr     = req_addr;
    assign bus2.req_wdata    = req_wdata;
    assign bus2.rsp_ready    = rsp_ready;

    dmem_bytelane #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .READ_LATENCY(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    dmem_bytelane #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .READ_LATENCY(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic drive_req(input op_t op);
        req_valid    = 1'b1;
        req_write    = op.wr;
        req_size     = op.sz;
        req_unsigned = op.uns;
        req_addr     = op.addr;
        req_wdata    = op.wd;
    endtask

    // Issues one request to both instances (rsp_ready high) and records when each responds.
    task automatic do_op(input op_t op, output logic [31:0] rd1, output logic f1,
                         output int lat1, output logic [31:0] rd2, output logic f2,
                         output int lat2);
        int n;
        rd1 = 32'h0; rd2 = 32'h0; f1 = 1'b0; f2 = 1'b0; lat1 = -1; lat2 = -1;
        @(negedge clk);
        n = 0;
        while (!(bus1.req_ready && bus2.req_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        drive_req(op);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (bus1.rsp_valid && lat1 < 0) begin
                lat1 = c; rd1 = bus1.rsp_rdata; f1 = bus1.rsp_fault;
            end
            if (bus2.rsp_valid && lat2 < 0) begin
                lat2 = c; rd2 = bus2.rsp_rdata; f2 = bus2.rsp_fault;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus1.req_ready, bus1.rsp_valid, bus1.rsp_fault, bus1.rsp_rdata} !== 35'h0) begin
            errors++;
            $display("FAIL reset dut1: got ready=%b valid=%b fault=%b rdata=%h, expected all 0",
                     bus1.req_ready, bus1.rsp_valid, bus1.rsp_fault, bus1.rsp_rdata);
        end
        checks++;
        if ({bus2.req_ready, bus2.rsp_valid, bus2.rsp_fault, bus2.rsp_rdata} !== 35'h0) begin
            errors++;
            $display("FAIL reset dut2: got ready=%b valid=%b fault=%b rdata=%h, expected all 0",
                     bus2.req_ready, bus2.rsp_valid, bus2.rsp_fault, bus2.rsp_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus1.req_ready, bus2.req_ready} !== 2'b11) begin
            errors++;
            $display("FAIL reset release ready: got %b%b expected 11",
                     bus1.req_ready, bus2.req_ready);
        end
    endtask

    task automatic test_word();
        op_t ops [2];
        logic [31:0] rd1, rd2;
        logic f1, f2;
        int lat1, lat2;
        ops[0] = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
        ops[1] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF};
        for (int i = 0; i < 2; i++) begin
            do_op(ops[i], rd1, f1, lat1, rd2, f2, lat2);
            checks++;
            if ({f1, rd1} !== {ops[i].f, ops[i].exp}) begin
                errors++;
                $display("FAIL word[%0d] dut1: got fault=%b rdata=%h expected fault=%b rdata=%h",
                         i, f1, rd1, ops[i].f, ops[i].exp);
            end
            checks++;
            if ({f2, rd2} !== {ops[i].f, ops[i].exp}) begin
                errors++;
                $display("FAIL word[%0d] dut2: got fault=%b rdata=%h expected fault=%b rdata=%h",
                         i, f2, rd2, ops[i].f, ops[i].exp);
            end
            checks++;
            if (lat1 !== 1 || lat2 !== 2) begin
                errors++;
                $display("FAIL word[%0d] latency: got %0d/%0d expected 1/2", i, lat1, lat2);
            end
        end
    endtask

    task automatic test_byte_lanes();
        op_t ops [8];
        logic [31:0] rd1, rd2;
        logic f1, f2;
        int lat1, lat2;
        ops[0] = '{1'b1, 2'b10, 1'b0, 32'h20, 32'h00000000, 1'b0, 32'h0};
        ops[1] = '{1'b1, 2'b00, 1'b0, 32'h21, 32'h123456A5, 1'b0, 32'h0};
        ops[2] = '{1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF8001, 1'b0, 32'h0};
        ops[3] = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h8001A500};
        ops[4] = '{1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1'b0, 32'hFFFFFFA5};
        ops[5] = '{1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b0, 32'h000000A5};
        ops[6] = '{1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0, 32'hFFFF8001};
        ops[7] = '{1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0, 32'h00008001};
        for (int i = 0; i < 8; i++) begin
            do_op(ops[i], rd1, f1, lat1, rd2, f2, lat2);
            checks++;
            if ({f1, rd1} !== {ops[i].f, ops[i].exp}) begin
                errors++;
                $display("FAIL lanes[%0d] dut1: got fault=%b rdata=%h expected fault=%b rdata=%h",
                         i, f1, rd1, ops[i].f, ops[i].exp);
            end
            checks++;
            if ({f2, rd2} !== {ops[i].f, ops[i].exp}) begin
                errors++;
                $display("FAIL lanes[%0d] dut2: got fault=%b rdata=%h expected fault=%b rdata=%h",
                         i, f2, rd2, ops[i].f, ops[i].exp);
            end
            checks++;
            if (lat1 !== 1 || lat2 !== 2) begin
                errors++;
                $display("FAIL lanes[%0d] latency: got %0d/%0d expected 1/2", i, lat1, lat2);
            end
        end
    endtask

    task automatic test_backpressure();
        op_t ld;
        op_t junk;
        ld   = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h8001A500};
        junk = '{1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0};
        @(negedge clk);
        rsp_ready = 1'b0;
        drive_req(ld);
        @(negedge clk);
        // A store presented while busy must be ignored.
        drive_req(junk);
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if ({bus1.rsp_valid, bus1.req_ready, bus1.rsp_rdata} !== {2'b10, 32'h8001A500}) begin
                errors++;
                $display("FAIL stall dut1 c%0d: got valid=%b ready=%b rdata=%h expected 1/0/8001a500",
                         c, bus1.rsp_valid, bus1.req_ready, bus1.rsp_rdata);
            end
            if (c >= 2) begin
                checks++;
                if ({bus2.rsp_valid, bus2.req_ready, bus2.rsp_rdata} !== {2'b10, 32'h8001A500}) begin
                    errors++;
                    $display("FAIL stall dut2 c%0d: got valid=%b ready=%b rdata=%h expected 1/0/8001a500",
                             c, bus2.rsp_valid, bus2.req_ready, bus2.rsp_rdata);
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus1.req_ready, bus1.rsp_valid, bus2.req_ready, bus2.rsp_valid} !== 4'b1010) begin
            errors++;
            $display("FAIL stall release: got ready/valid %b%b %b%b expected 10 10",
                     bus1.req_ready, bus1.rsp_valid, bus2.req_ready, bus2.rsp_valid);
        end
    endtask

    task automatic test_faults();
        op_t ops [8];
        logic [31:0] rd1, rd2;
        logic f1, f2;
        int lat1, lat2;
        ops[0] = '{1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1'b1, 32'h0};
        ops[1] = '{1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF, 1'b1, 32'h0};
        ops[2] = '{1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0};
        ops[3] = '{1'b1, 2'b11, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0};
        ops[4] = '{1'b1, 2'b10, 1'b0, 32'h400, 32'hFFFFFFFF, 1'b1, 32'h0};
        ops[5] = '{1'b1, 2'b10, 1'b0, 32'h420, 32'hFFFFFFFF, 1'b1, 32'h0};
        ops[6] = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h8001A500};
        ops[7] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF};
        for (int i = 0; i < 8; i++) begin
            do_op(ops[i], rd1, f1, lat1, rd2, f2, lat2);
            checks++;
            if ({f1, rd1} !== {ops[i].f, ops[i].exp}) begin
                errors++;
                $display("FAIL fault[%0d] dut1: got fault=%b rdata=%h expected fault=%b rdata=%h",
                         i, f1, rd1, ops[i].f, ops[i].exp);
            end
            checks++;
            if ({f2, rd2} !== {ops[i].f, ops[i].exp}) begin
                errors++;
                $display("FAIL fault[%0d] dut2: got fault=%b rdata=%h expected fault=%b rdata=%h",
                         i, f2, rd2, ops[i].f, ops[i].exp);
            end
            checks++;
            if (lat1 !== 1 || lat2 !== 2) begin
                errors++;
                $display("FAIL fault[%0d] latency: got %0d/%0d expected 1/2", i, lat1, lat2);
            end
        end
    endtask

    task automatic test_reset_midop();
        op_t st;
        op_t ld;
        logic [31:0] rd1, rd2;
        logic f1, f2;
        int lat1, lat2;
        st = '{1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678, 1'b0, 32'h0};
        ld = '{1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, 32'h12345678};
        do_op(st, rd1, f1, lat1, rd2, f2, lat2);
        @(negedge clk);
        drive_req(ld);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus1.rsp_valid, bus2.rsp_valid, bus1.req_ready, bus2.req_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL midop reset: got valid %b%b ready %b%b expected 00 00",
                     bus1.rsp_valid, bus2.rsp_valid, bus1.req_ready, bus2.req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if ({bus1.rsp_valid, bus2.rsp_valid} !== 2'b00) begin
                errors++;
                $display("FAIL midop stray rsp c%0d: got valid %b%b expected 00",
                         c, bus1.rsp_valid, bus2.rsp_valid);
            end
        end
        checks++;
        if ({bus1.req_ready, bus2.req_ready} !== 2'b11) begin
            errors++;
            $display("FAIL midop ready: got %b%b expected 11", bus1.req_ready, bus2.req_ready);
        end
        do_op(ld, rd1, f1, lat1, rd2, f2, lat2);
        checks++;
        if ({f1, rd1, f2, rd2} !== {1'b0, 32'h12345678, 1'b0, 32'h12345678}) begin
            errors++;
            $display("FAIL midop readback: got %b/%h %b/%h expected 0/12345678 0/12345678",
                     f1, rd1, f2, rd2);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_lanes();
        test_backpressure();
        test_faults();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
